// File: rtl/aux_reply_timeout_timer_if.sv
// Request/reply handshake bundle between the AUX transmitter/control FSM
// and the reply-timeout timer.
interface aux_reply_timeout_timer_if #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned RTRY_W = 3
);

  logic              mux_aux_out_vld;
  logic              bdi_timer_reset;
  logic              timer_abort;
  logic [CNT_W-1:0]  cfg_timeout;
  logic              timer_timeout;
  logic              retry_exhausted;
  logic              timer_busy;
  logic [RTRY_W-1:0] retry_cnt;

  // Control side: drives requests and reply detection, observes the timer.
  modport master (
    output mux_aux_out_vld,
    output bdi_timer_reset,
    output timer_abort,
    output cfg_timeout,
    input  timer_timeout,
    input  retry_exhausted,
    input  timer_busy,
    input  retry_cnt
  );

  // Timer side.
  modport slave (
    input  mux_aux_out_vld,
    input  bdi_timer_reset,
    input  timer_abort,
    input  cfg_timeout,
    output timer_timeout,
    output retry_exhausted,
    output timer_busy,
    output retry_cnt
  );

endinterface

// File: rtl/aux_reply_timeout_timer.sv
// AUX reply-timeout timer. Arms on the falling edge of mux_aux_out_vld,
// counts a programmable number of cycles and pulses timer_timeout when no
// reply arrives. Consecutive timeouts are counted per transaction and the
// MAX_TIMEOUTS-th one also raises retry_exhausted.
// The interface instance must be parameterised with the same CNT_W/RTRY_W.
module aux_reply_timeout_timer #(
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned DEFAULT_TIMEOUT = 40,
  parameter int unsigned RTRY_W          = 3,
  parameter int unsigned MAX_TIMEOUTS    = 7
) (
  input logic                    clk,
  input logic                    rst_n,
  aux_reply_timeout_timer_if.slave bus
);

  localparam logic [CNT_W-1:0]  DefLimit  = CNT_W'(DEFAULT_TIMEOUT);
  localparam logic [RTRY_W-1:0] RetryLast = RTRY_W'(MAX_TIMEOUTS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StTx,
    StCount
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  limit_q, limit_d;
  logic [RTRY_W-1:0] retry_q, retry_d;
  logic              timeout_q, timeout_d;
  logic              exhausted_q, exhausted_d;
  logic              busy_q, busy_d;
  logic              expire;

  // Limit is never 0 once COUNT is entered, so limit-1 cannot underflow there.
  assign expire = (count_q == (limit_q - CNT_W'(1)));

  // Next-state and output decode, abort > reply > retry launch > expiry.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    limit_d     = limit_q;
    retry_d     = retry_q;
    timeout_d   = 1'b0;
    exhausted_d = 1'b0;

    if (bus.timer_abort) begin
      state_d = StIdle;
      count_d = '0;
      retry_d = '0;
    end else if (bus.bdi_timer_reset) begin
      // A reply ends the transaction; only a running count is stopped.
      retry_d = '0;
      if (state_q == StCount) begin
        state_d = StIdle;
        count_d = '0;
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.mux_aux_out_vld) begin
            state_d = StTx;
          end
        end
        StTx: begin
          if (!bus.mux_aux_out_vld) begin
            // cfg_timeout is captured only here; later changes are ignored.
            state_d = StCount;
            count_d = '0;
            limit_d = (bus.cfg_timeout == '0) ? DefLimit : bus.cfg_timeout;
          end
        end
        StCount: begin
          if (bus.mux_aux_out_vld) begin
            // Retry launched before expiry: cancel without a timeout.
            state_d = StTx;
            count_d = '0;
          end else if (expire) begin
            state_d   = StIdle;
            count_d   = '0;
            timeout_d = 1'b1;
            if (retry_q == RetryLast) begin
              exhausted_d = 1'b1;
              retry_d     = '0;
            end else begin
              retry_d = retry_q + RTRY_W'(1);
            end
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = StIdle;
          count_d = '0;
        end
      endcase
    end

    busy_d = (state_d == StCount);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      count_q     <= '0;
      limit_q     <= '0;
      retry_q     <= '0;
      timeout_q   <= 1'b0;
      exhausted_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      limit_q     <= limit_d;
      retry_q     <= retry_d;
      timeout_q   <= timeout_d;
      exhausted_q <= exhausted_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.timer_timeout   = timeout_q;
  assign bus.retry_exhausted = exhausted_q;
  assign bus.timer_busy      = busy_q;
  assign bus.retry_cnt       = retry_q;

endmodule

// File: tb/tb_aux_reply_timeout_timer.sv
// Bench for aux_reply_timeout_timer: a table of transaction scenarios plus a
// hand-written reset sequence. Expected timeout pulses are queued when a
// request is released and compared when the DUT pulses.
module tb_aux_reply_timeout_timer;

  localparam int CNT_W  = 16;
  localparam int RTRY_W = 3;
  localparam int MAXT   = 7;
  localparam int NVEC   = 13;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  aux_reply_timeout_timer_if #(.CNT_W(CNT_W), .RTRY_W(RTRY_W)) bus ();

  aux_reply_timeout_timer #(
    .CNT_W          (CNT_W),
    .DEFAULT_TIMEOUT(40),
    .RTRY_W         (RTRY_W),
    .MAX_TIMEOUTS   (MAXT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // intr: 0 none, 1 reply (bdi), 2 retry launch, 3 abort; intr_at = count value.
  typedef struct {
    int vld_len;
    int cfg;
    int cfg_late;
    int exp_l;
    int intr;
    int intr_at;
    int exp_retry;
    bit exp_exh;
  } vec_t;

  typedef struct {
    int cyc;
    int retry;
    bit exh;
  } pulse_t;

  vec_t   vecs[NVEC];
  pulse_t sb[$];
  int     n_vec = 0;
  int     n_err = 0;
  int     cyc = 0;
  int     busy_total = 0;
  int     pulse_total = 0;
  bit     mon_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops the scoreboard on every timeout pulse.
  initial forever begin
    pulse_t p;
    @(negedge clk);
    if (mon_en && rst_n) begin
      if (bus.timer_busy) busy_total++;
      if (bus.timer_timeout) begin
        pulse_total++;
        if (sb.size() == 0) begin
          check("unexpected_pulse", 1, 0);
        end else begin
          p = sb.pop_front();
          check("pulse_cycle", cyc, p.cyc);
          check("pulse_retry_cnt", int'(bus.retry_cnt), p.retry);
          check("pulse_exhausted", int'(bus.retry_exhausted), int'(p.exh));
        end
      end else if (bus.retry_exhausted) begin
        check("exhausted_without_timeout", 1, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic run_vec(input int idx, input vec_t v);
    int e_cyc;
    int b0;
    bus.cfg_timeout = CNT_W'(v.cfg);
    b0 = busy_total;
    bus.mux_aux_out_vld = 1'b1;
    repeat (v.vld_len) @(negedge clk);
    bus.mux_aux_out_vld = 1'b0;
    @(posedge clk);  // edge E
    #1 e_cyc = cyc;
    if (v.intr == 0) sb.push_back('{cyc: e_cyc + v.exp_l, retry: v.exp_retry, exh: v.exp_exh});
    @(negedge clk);  // count == 0
    check($sformatf("v%0d_busy_after_E", idx), int'(bus.timer_busy), 1);
    if (v.intr == 0) begin
      @(negedge clk);
      bus.cfg_timeout = CNT_W'(v.cfg_late);
    end else begin
      repeat (v.intr_at) @(negedge clk);
      case (v.intr)
        1: bus.bdi_timer_reset = 1'b1;
        2: bus.mux_aux_out_vld = 1'b1;
        default: bus.timer_abort = 1'b1;
      endcase
      @(negedge clk);
      bus.bdi_timer_reset = 1'b0;
      bus.mux_aux_out_vld = 1'b0;
      bus.timer_abort = 1'b0;
      check($sformatf("v%0d_busy_after_intr", idx), int'(bus.timer_busy), 0);
      if (v.intr == 2) begin
        check($sformatf("v%0d_retry_kept", idx), int'(bus.retry_cnt), v.exp_retry - 1);
        @(posedge clk);  // edge E'
        #1 e_cyc = cyc;
        sb.push_back('{cyc: e_cyc + v.exp_l, retry: v.exp_retry, exh: v.exp_exh});
      end else begin
        check($sformatf("v%0d_retry_cleared", idx), int'(bus.retry_cnt), 0);
      end
    end
    repeat (v.exp_l + 4) @(negedge clk);
    check($sformatf("v%0d_pulse_drained", idx), sb.size(), 0);
    sb.delete();
    check($sformatf("v%0d_idle_busy", idx), int'(bus.timer_busy), 0);
    check($sformatf("v%0d_retry_after", idx), int'(bus.retry_cnt), v.exp_retry);
    if (v.intr == 0) check($sformatf("v%0d_busy_cycles", idx), busy_total - b0, v.exp_l);
  endtask

  initial begin
    int p0;
    bus.mux_aux_out_vld = 1'b0;
    bus.bdi_timer_reset = 1'b0;
    bus.timer_abort     = 1'b0;
    bus.cfg_timeout     = '0;
    rst_n = 1'b0;

    //            vld cfg late  L intr at retry exh
    vecs[0]  = '{5, 0,  0,   40, 0, 0,  1, 1'b0};  // default timeout
    vecs[1]  = '{2, 3,  100, 3,  0, 0,  2, 1'b0};  // late cfg change ignored
    vecs[2]  = '{1, 1,  1,   1,  0, 0,  3, 1'b0};  // minimum limit
    vecs[3]  = '{3, 10, 10,  10, 1, 9,  0, 1'b0};  // reply coincident with expiry
    vecs[4]  = '{1, 2,  2,   2,  0, 0,  1, 1'b0};  // exhaustion run
    vecs[5]  = '{2, 2,  2,   2,  0, 0,  2, 1'b0};
    vecs[6]  = '{1, 2,  2,   2,  0, 0,  3, 1'b0};
    vecs[7]  = '{3, 2,  2,   2,  0, 0,  4, 1'b0};
    vecs[8]  = '{1, 2,  2,   2,  0, 0,  5, 1'b0};
    vecs[9]  = '{4, 2,  2,   2,  0, 0,  6, 1'b0};
    vecs[10] = '{1, 2,  2,   2,  0, 0,  0, 1'b1};
    vecs[11] = '{2, 0,  0,   40, 2, 20, 1, 1'b0};  // retry before expiry
    vecs[12] = '{2, 0,  0,   40, 3, 15, 0, 1'b0};  // abort

    repeat (3) @(negedge clk);
    check("reset_timeout", int'(bus.timer_timeout), 0);
    check("reset_exhausted", int'(bus.retry_exhausted), 0);
    check("reset_busy", int'(bus.timer_busy), 0);
    check("reset_retry_cnt", int'(bus.retry_cnt), 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

    // Reset in the middle of a count: outputs clear asynchronously and no
    // pulse follows release without a new request.
    bus.cfg_timeout = '0;
    bus.mux_aux_out_vld = 1'b1;
    @(negedge clk);
    bus.mux_aux_out_vld = 1'b0;
    repeat (12) @(negedge clk);
    check("rst_busy_before", int'(bus.timer_busy), 1);
    p0 = pulse_total;
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_busy", int'(bus.timer_busy), 0);
    check("rst_async_timeout", int'(bus.timer_timeout), 0);
    check("rst_async_exhausted", int'(bus.retry_exhausted), 0);
    check("rst_async_retry_cnt", int'(bus.retry_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("rst_no_pulse_after", pulse_total - p0, 0);
    check("rst_busy_after", int'(bus.timer_busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
